// File: rtl/cmos_capture_pro_if.sv
// Pixel-stream bundle of the DVP capture block: sensor byte side in, framed pixel words out.
// master is the capture block's view, slave is the sensor/sink view.
interface cmos_capture_pro_if #(
    parameter int BPP = 2
);
    logic               vsync;
    logic               href;
    logic [7:0]         din;
    logic [8*BPP-1:0]   dout;
    logic               dout_sop;
    logic               dout_eop;
    logic               dout_vld;

    modport master (
        input  vsync, href, din,
        output dout, dout_sop, dout_eop, dout_vld
    );

    modport slave (
        output vsync, href, din,
        input  dout, dout_sop, dout_eop, dout_vld
    );
endinterface

// File: rtl/cmos_capture_pro.sv
// DVP camera capture front end: assembles sensor bytes into 8/16-bit pixel words with
// sop/eop/vld framing, runtime frame decimation and line/frame length checking.
module cmos_capture_pro #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BPP      = 2,
    parameter int SWAP     = 0,
    parameter int SKIP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [SKIP_W-1:0] skip_n,
    cmos_capture_pro_if.master cam,
    output logic              err_line,
    output logic              err_frame,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, CAPT, DROP} state_t;

    localparam int LINE_B = BPP * H_ACTIVE;
    localparam int CB_W   = (LINE_B > 1)   ? $clog2(LINE_B)   : 1;
    localparam int CV_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    localparam logic [CB_W-1:0] B_LAST = CB_W'(LINE_B - 1);
    localparam logic [CB_W-1:0] B_PIX0 = CB_W'(BPP - 1);
    localparam logic [CV_W-1:0] V_LAST = CV_W'(V_ACTIVE - 1);

    state_t             state_q, state_d;
    logic [1:0]         vs_q, vs_d;
    logic [CB_W-1:0]    cnt_b_q, cnt_b_d;
    logic [CV_W-1:0]    cnt_v_q, cnt_v_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic [7:0]         byte_q, byte_d;
    logic [8*BPP-1:0]   dout_q, dout_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic               vld_q, vld_d;
    logic               err_line_q, err_line_d;
    logic               err_frame_q, err_frame_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               vs_fall;
    logic               pix_last;
    logic               b_wrap;
    logic               v_last;
    logic [8*BPP-1:0]   pix_word;

    assign vs_fall  = vs_q[1] & ~vs_q[0];
    assign pix_last = (BPP == 1) || cnt_b_q[0];
    assign b_wrap   = (cnt_b_q == B_LAST);
    assign v_last   = (cnt_v_q == V_LAST);

    // byte_q holds the previous href byte; href is continuous within a line, so it is the pair's first byte.
    generate
        if (BPP == 2) begin : g_bpp2
            assign pix_word = (SWAP != 0) ? {cam.din, byte_q} : {byte_q, cam.din};
        end else begin : g_bpp1
            assign pix_word = cam.din;
        end
    endgenerate

    always_comb begin
        // NOTE: every variable gets its hold/idle value first so no path through the case infers a latch.
        state_d     = state_q;
        vs_d        = {vs_q[0], cam.vsync};
        cnt_b_d     = cnt_b_q;
        cnt_v_d     = cnt_v_q;
        skip_d      = skip_q;
        byte_d      = cam.din;
        dout_d      = dout_q;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        vld_d       = 1'b0;
        err_line_d  = 1'b0;
        err_frame_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (state_q == IDLE) begin
            if (enable) begin
                state_d = WAIT;
            end
        end else if (vs_fall) begin
            // A new frame always restarts counting; a frame still in capture is reported as short.
            err_frame_d = (state_q == CAPT);
            cnt_b_d     = '0;
            cnt_v_d     = '0;
            if (!enable) begin
                state_d = IDLE;
            end else if (skip_q == '0) begin
                state_d = CAPT;
                skip_d  = skip_n;
            end else begin
                state_d = DROP;
                skip_d  = skip_q - SKIP_W'(1);
            end
        end else if (state_q == CAPT) begin
            if (cam.href) begin
                if (pix_last) begin
                    dout_d = pix_word;
                    vld_d  = 1'b1;
                    sop_d  = (cnt_v_q == '0) && (cnt_b_q == B_PIX0);
                    eop_d  = v_last && b_wrap;
                    if (v_last && b_wrap) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
                if (b_wrap) begin
                    cnt_b_d = '0;
                    if (v_last) begin
                        cnt_v_d = '0;
                        state_d = WAIT;
                    end else begin
                        cnt_v_d = cnt_v_q + CV_W'(1);
                    end
                end else begin
                    cnt_b_d = cnt_b_q + CB_W'(1);
                end
            end else if (cnt_b_q != '0) begin
                // href dropped mid-line: discard the partial line and let the sensor retry it.
                err_line_d = 1'b1;
                cnt_b_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vs_q        <= '0;
            cnt_b_q     <= '0;
            cnt_v_q     <= '0;
            skip_q      <= '0;
            byte_q      <= '0;
            dout_q      <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            vld_q       <= 1'b0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            vs_q        <= vs_d;
            cnt_b_q     <= cnt_b_d;
            cnt_v_q     <= cnt_v_d;
            skip_q      <= skip_d;
            byte_q      <= byte_d;
            dout_q      <= dout_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            vld_q       <= vld_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cam.dout     = dout_q;
    assign cam.dout_sop = sop_q;
    assign cam.dout_eop = eop_q;
    assign cam.dout_vld = vld_q;
    assign err_line     = err_line_q;
    assign err_frame    = err_frame_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_cmos_capture_pro.sv
// Bench for cmos_capture_pro: four builds (16-bit MSB-first, 16-bit LSB-first, 8-bit, 8-bit 1x1)
// share one sensor stream; a line/frame-level model predicts pixels, error pulses and frame counts.
module tb_cmos_capture_pro;

    localparam int N = 4;
    localparam int P_BPP  [N] = '{2, 2, 1, 1};
    localparam int P_SWAP [N] = '{0, 1, 0, 0};
    localparam int P_H    [N] = '{4, 4, 4, 1};
    localparam int P_V    [N] = '{2, 2, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] skip_n = 4'd0;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [7:0] din = 8'd0;

    logic [N-1:0] err_line_w;
    logic [N-1:0] err_frame_w;
    logic [15:0]  fcnt_w [N];

    always #5 clk = ~clk;

    cmos_capture_pro_if #(.BPP(2)) if0 ();
    cmos_capture_pro_if #(.BPP(2)) if1 ();
    cmos_capture_pro_if #(.BPP(1)) if2 ();
    cmos_capture_pro_if #(.BPP(1)) if3 ();

    assign if0.vsync = vsync; assign if0.href = href; assign if0.din = din;
    assign if1.vsync = vsync; assign if1.href = href; assign if1.din = din;
    assign if2.vsync = vsync; assign if2.href = href; assign if2.din = din;
    assign if3.vsync = vsync; assign if3.href = href; assign if3.din = din;

    cmos_capture_pro #(.H_ACTIVE(4), .V_ACTIVE(2), .BPP(2), .SWAP(0), .SKIP_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .skip_n(skip_n), .cam(if0.master),
        .err_line(err_line_w[0]), .err_frame(err_frame_w[0]), .frame_cnt(fcnt_w[0]));
    cmos_capture_pro #(.H_ACTIVE(4), .V_ACTIVE(2), .BPP(2), .SWAP(1), .SKIP_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .skip_n(skip_n), .cam(if1.master),
        .err_line(err_line_w[1]), .err_frame(err_frame_w[1]), .frame_cnt(fcnt_w[1]));
    cmos_capture_pro #(.H_ACTIVE(4), .V_ACTIVE(2), .BPP(1), .SWAP(0), .SKIP_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .skip_n(skip_n), .cam(if2.master),
        .err_line(err_line_w[2]), .err_frame(err_frame_w[2]), .frame_cnt(fcnt_w[2]));
    cmos_capture_pro #(.H_ACTIVE(1), .V_ACTIVE(1), .BPP(1), .SWAP(0), .SKIP_W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .skip_n(skip_n), .cam(if3.master),
        .err_line(err_line_w[3]), .err_frame(err_frame_w[3]), .frame_cnt(fcnt_w[3]));

    // Observed pixels as {sop, eop, word[15:0]}, plus running error pulse counts.
    logic [17:0] act_q [N][$];
    int          a_el [N];
    int          a_ef [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            a_el[i] = 0;
            a_ef[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (if0.dout_vld) act_q[0].push_back({if0.dout_sop, if0.dout_eop, if0.dout});
        if (if1.dout_vld) act_q[1].push_back({if1.dout_sop, if1.dout_eop, if1.dout});
        if (if2.dout_vld) act_q[2].push_back({if2.dout_sop, if2.dout_eop, 8'h00, if2.dout});
        if (if3.dout_vld) act_q[3].push_back({if3.dout_sop, if3.dout_eop, 8'h00, if3.dout});
        for (int i = 0; i < N; i++) begin
            if (err_line_w[i])  a_el[i] = a_el[i] + 1;
            if (err_frame_w[i]) a_ef[i] = a_ef[i] + 1;
        end
    end

    // Reference model state, per build.
    logic [17:0] exp_q [N][$];
    bit          m_armed [N];
    bit          m_cap [N];
    int          m_line [N];
    int          m_pos [N];
    int          m_skip [N];
    int          m_fcnt [N];
    int          m_el [N];
    int          m_ef [N];
    logic [7:0]  m_first [N];
    int          act_rd [N];
    int          el_base [N];
    int          ef_base [N];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            m_armed[i] = enable;
            m_cap[i]   = 1'b0;
            m_line[i]  = 0;
            m_pos[i]   = 0;
            m_skip[i]  = 0;
            m_fcnt[i]  = 0;
            m_el[i]    = 0;
            m_ef[i]    = 0;
            m_first[i] = 8'h00;
            act_rd[i]  = act_q[i].size();
            el_base[i] = a_el[i];
            ef_base[i] = a_ef[i];
        end
    endtask

    task automatic set_enable(input logic v);
        tick(1);
        enable = v;
        if (v) begin
            for (int i = 0; i < N; i++) m_armed[i] = 1'b1;
        end
        tick(2);
    endtask

    // Frame boundary: the kept/dropped decision follows the keep-1-drop-skip_n rule.
    task automatic vsync_fall();
        tick(1);
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(4);
        for (int i = 0; i < N; i++) begin
            if (m_armed[i]) begin
                if (m_cap[i]) m_ef[i]++;
                m_line[i] = 0;
                m_pos[i]  = 0;
                if (!enable) begin
                    m_armed[i] = 1'b0;
                    m_cap[i]   = 1'b0;
                end else if (m_skip[i] == 0) begin
                    m_cap[i]  = 1'b1;
                    m_skip[i] = int'(skip_n);
                end else begin
                    m_cap[i]  = 1'b0;
                    m_skip[i] = m_skip[i] - 1;
                end
            end
        end
    endtask

    // One href burst of n bytes (sequential from start, or random), then href low.
    task automatic send_line(input int n, input int start, input bit rnd);
        logic [7:0]  bq [$];
        logic [15:0] w;
        logic        sop;
        logic        eop;
        int          bpp;
        for (int k = 0; k < n; k++) bq.push_back(rnd ? 8'($urandom) : 8'(start + k));
        for (int k = 0; k < n; k++) begin
            tick(1);
            href = 1'b1;
            din  = bq[k];
        end
        tick(1);
        href = 1'b0;
        din  = 8'($urandom);
        tick(3);
        for (int i = 0; i < N; i++) begin
            bpp = P_BPP[i];
            for (int k = 0; k < n; k++) begin
                if (!m_cap[i]) break;
                if (m_pos[i] % bpp == 0) m_first[i] = bq[k];
                if (m_pos[i] % bpp == bpp - 1) begin
                    if (bpp == 1)            w = {8'h00, bq[k]};
                    else if (P_SWAP[i] != 0) w = {bq[k], m_first[i]};
                    else                     w = {m_first[i], bq[k]};
                    sop = (m_line[i] == 0) && (m_pos[i] == bpp - 1);
                    eop = (m_line[i] == P_V[i] - 1) && (m_pos[i] == bpp * P_H[i] - 1);
                    exp_q[i].push_back({sop, eop, w});
                end
                m_pos[i]++;
                if (m_pos[i] == bpp * P_H[i]) begin
                    m_pos[i] = 0;
                    m_line[i]++;
                    if (m_line[i] == P_V[i]) begin
                        m_line[i] = 0;
                        m_cap[i]  = 1'b0;
                        m_fcnt[i]++;
                    end
                end
            end
            if (m_cap[i] && m_pos[i] != 0) begin
                m_el[i]++;
                m_pos[i] = 0;
            end
        end
    endtask

    task automatic check_step(input string tag);
        int n_act;
        int n_min;
        tick(4);
        for (int i = 0; i < N; i++) begin
            n_act = act_q[i].size() - act_rd[i];
            check($sformatf("%s/u%0d/vld_count", tag, i), 64'(n_act), 64'(exp_q[i].size()));
            n_min = (n_act < exp_q[i].size()) ? n_act : exp_q[i].size();
            for (int k = 0; k < n_min; k++)
                check($sformatf("%s/u%0d/pix%0d", tag, i, k), 64'(act_q[i][act_rd[i] + k]), 64'(exp_q[i][k]));
            act_rd[i] += n_act;
            exp_q[i].delete();
            check($sformatf("%s/u%0d/err_line", tag, i), 64'(a_el[i] - el_base[i]), 64'(m_el[i]));
            check($sformatf("%s/u%0d/err_frame", tag, i), 64'(a_ef[i] - ef_base[i]), 64'(m_ef[i]));
            check($sformatf("%s/u%0d/frame_cnt", tag, i), 64'(fcnt_w[i]), 64'(m_fcnt[i] & 16'hFFFF));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/u0"}, {if0.dout, if0.dout_vld, if0.dout_sop, if0.dout_eop, err_line_w[0], err_frame_w[0], fcnt_w[0]}, 64'd0);
        check({tag, "/u1"}, {if1.dout, if1.dout_vld, if1.dout_sop, if1.dout_eop, err_line_w[1], err_frame_w[1], fcnt_w[1]}, 64'd0);
        check({tag, "/u2"}, {if2.dout, if2.dout_vld, if2.dout_sop, if2.dout_eop, err_line_w[2], err_frame_w[2], fcnt_w[2]}, 64'd0);
        check({tag, "/u3"}, {if3.dout, if3.dout_vld, if3.dout_sop, if3.dout_eop, err_line_w[3], err_frame_w[3], fcnt_w[3]}, 64'd0);
    endtask

    initial begin
        int nl;
        int len;

        // Reset state
        tick(3);
        check_zero("reset");
        rst_n = 1'b1;
        model_reset();
        tick(2);

        // Capture disabled: falls and data are ignored
        vsync_fall();
        send_line(8, 8'h30, 1'b0);
        send_line(8, 8'h40, 1'b0);
        check_step("disabled");

        // Known 4x2 frame of bytes 0x01..0x10
        set_enable(1'b1);
        vsync_fall();
        send_line(8, 8'h01, 1'b0);
        send_line(8, 8'h09, 1'b0);
        check_step("frame_seq");

        // Short line on line 0, then retried line and line 1
        vsync_fall();
        send_line(3, 0, 1'b1);
        send_line(8, 0, 1'b1);
        send_line(8, 0, 1'b1);
        check_step("short_line");

        // Short frame: fall after one line, then a full frame
        vsync_fall();
        send_line(8, 0, 1'b1);
        vsync_fall();
        send_line(8, 0, 1'b1);
        send_line(8, 0, 1'b1);
        check_step("short_frame");

        // Decimation: keep 1, drop 2, over six frames
        skip_n = 4'd2;
        for (int f = 0; f < 6; f++) begin
            vsync_fall();
            send_line(8, 0, 1'b1);
            send_line(8, 0, 1'b1);
        end
        check_step("skip");
        skip_n = 4'd0;

        // Enable drop mid-frame: frame completes, next frame is not captured
        vsync_fall();
        send_line(8, 0, 1'b1);
        set_enable(1'b0);
        send_line(8, 0, 1'b1);
        check_step("en_drop");
        vsync_fall();
        send_line(8, 0, 1'b1);
        send_line(8, 0, 1'b1);
        check_step("en_off");
        set_enable(1'b1);

        // Async reset mid-line
        vsync_fall();
        for (int k = 0; k < 3; k++) begin
            tick(1);
            href = 1'b1;
            din  = 8'($urandom);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        href = 1'b0;
        tick(2);
        rst_n = 1'b1;
        model_reset();
        tick(2);
        vsync_fall();
        send_line(8, 0, 1'b1);
        send_line(8, 0, 1'b1);
        check_step("after_reset");

        // Randomised frames: mixed decimation, short and extra lines
        for (int it = 0; it < 10; it++) begin
            skip_n = 4'($urandom_range(0, 2));
            vsync_fall();
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
                send_line(len, 0, 1'b1);
            end
            check_step($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
